// File: rtl/instruction_buffer_if.sv
// Fetch-to-decode handshake bundle for the dual-issue instruction buffer.
// master = fetch/decode side, slave = the buffer itself.
interface instruction_buffer_if;
  logic        fetch_inst_1_en;
  logic        fetch_inst_2_en;
  logic [31:0] pc_1_i;
  logic [31:0] pc_2_i;
  logic [31:0] inst_1_i;
  logic [31:0] inst_2_i;
  logic        is_branch_1_i;
  logic        is_branch_2_i;
  logic        fetch_ready;
  logic [1:0]  dec_accept;
  logic        dec_valid_1;
  logic        dec_valid_2;
  logic [31:0] dec_pc_1;
  logic [31:0] dec_pc_2;
  logic [31:0] dec_inst_1;
  logic [31:0] dec_inst_2;
  logic        dec_is_branch_1;
  logic        dec_is_branch_2;

  modport master (
    output fetch_inst_1_en, fetch_inst_2_en, pc_1_i, pc_2_i, inst_1_i, inst_2_i,
           is_branch_1_i, is_branch_2_i, dec_accept,
    input  fetch_ready, dec_valid_1, dec_valid_2, dec_pc_1, dec_pc_2,
           dec_inst_1, dec_inst_2, dec_is_branch_1, dec_is_branch_2
  );

  modport slave (
    input  fetch_inst_1_en, fetch_inst_2_en, pc_1_i, pc_2_i, inst_1_i, inst_2_i,
           is_branch_1_i, is_branch_2_i, dec_accept,
    output fetch_ready, dec_valid_1, dec_valid_2, dec_pc_1, dec_pc_2,
           dec_inst_1, dec_inst_2, dec_is_branch_1, dec_is_branch_2
  );
endinterface

// File: rtl/instruction_buffer.sv
// Dual-issue circular instruction queue between branch prediction and decode.
// Writes up to two entries per cycle at tail, presents the two oldest to decode.
module instruction_buffer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned PTR_W = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  instruction_buffer_if.slave  ib,
  output logic [PTR_W:0]       count
);

  localparam int unsigned CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        is_branch;
  } entry_t;

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] head_p1;
  logic [PTR_W-1:0] slot2_idx;
  logic [1:0]       acc;
  logic [1:0]       rd_n;
  logic [1:0]       wr_n;
  logic             wr_go;
  logic             valid_1;
  logic             valid_2;
  entry_t           rd_1;
  entry_t           rd_2;
  entry_t           wr_1;
  entry_t           wr_2;

  // Ready reflects only the current occupancy; reads this cycle are not credited.
  assign ib.fetch_ready = rst && (count_q <= CNT_W'(DEPTH - 2));
  assign wr_go          = ib.fetch_ready && !flush;

  assign wr_1      = '{pc: ib.pc_1_i, inst: ib.inst_1_i, is_branch: ib.is_branch_1_i};
  assign wr_2      = '{pc: ib.pc_2_i, inst: ib.inst_2_i, is_branch: ib.is_branch_2_i};
  assign slot2_idx = tail_q + PTR_W'(ib.fetch_inst_1_en);

  // Consume count clamped to the request (3 acts as 2) and to occupancy.
  always_comb begin
    acc  = (ib.dec_accept == 2'd3) ? 2'd2 : ib.dec_accept;
    rd_n = acc;
    if (count_q < CNT_W'(acc)) begin
      rd_n = count_q[1:0];
    end
    wr_n = 2'd0;
    if (wr_go) begin
      wr_n = {1'b0, ib.fetch_inst_1_en} + {1'b0, ib.fetch_inst_2_en};
    end
  end

  always_comb begin
    head_d  = head_q + PTR_W'(rd_n);
    tail_d  = tail_q + PTR_W'(wr_n);
    count_d = count_q + CNT_W'(wr_n) - CNT_W'(rd_n);
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage has no reset; validity is tracked entirely by count_q.
  always_ff @(posedge clk) begin
    if (wr_go && ib.fetch_inst_1_en) begin
      mem_q[tail_q] <= wr_1;
    end
    if (wr_go && ib.fetch_inst_2_en) begin
      mem_q[slot2_idx] <= wr_2;
    end
  end

  assign head_p1 = head_q + PTR_W'(1);
  assign valid_1 = (count_q != '0);
  assign valid_2 = (count_q >= CNT_W'(2));
  assign rd_1    = valid_1 ? mem_q[head_q]  : '0;
  assign rd_2    = valid_2 ? mem_q[head_p1] : '0;

  assign ib.dec_valid_1     = valid_1;
  assign ib.dec_valid_2     = valid_2;
  assign ib.dec_pc_1        = rd_1.pc;
  assign ib.dec_pc_2        = rd_2.pc;
  assign ib.dec_inst_1      = rd_1.inst;
  assign ib.dec_inst_2      = rd_2.inst;
  assign ib.dec_is_branch_1 = rd_1.is_branch;
  assign ib.dec_is_branch_2 = rd_2.is_branch;
  assign count              = count_q;

endmodule

// File: tb/tb_instruction_buffer.sv
// Self-checking bench for instruction_buffer: queue-based reference model checked
// every negative edge, plus directed scenarios with literal expectations.
module tb_instruction_buffer;
  localparam int unsigned DEPTH = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       flush = 1'b0;
  logic [4:0] count;

  instruction_buffer_if ibf ();

  instruction_buffer #(.DEPTH(DEPTH), .PTR_W(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .flush(flush),
    .ib   (ibf),
    .count(count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        br;
  } ent_t;

  ent_t mq[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: FIFO queue of entries, checked then advanced each cycle.
  always @(negedge clk) begin
    int   sz;
    int   a;
    int   eff;
    logic rdy;
    ent_t e0;
    ent_t e1;
    if (!rst) mq.delete();
    sz  = mq.size();
    e0  = '{pc: 32'h0, inst: 32'h0, br: 1'b0};
    e1  = '{pc: 32'h0, inst: 32'h0, br: 1'b0};
    if (sz >= 1) e0 = mq[0];
    if (sz >= 2) e1 = mq[1];
    rdy = rst && (sz <= int'(DEPTH) - 2);
    chk("m_count",   32'(count), 32'(sz));
    chk("m_ready",   32'(ibf.fetch_ready), 32'(rdy));
    chk("m_valid1",  32'(ibf.dec_valid_1), 32'(sz >= 1));
    chk("m_valid2",  32'(ibf.dec_valid_2), 32'(sz >= 2));
    chk("m_pc1",     ibf.dec_pc_1, e0.pc);
    chk("m_pc2",     ibf.dec_pc_2, e1.pc);
    chk("m_inst1",   ibf.dec_inst_1, e0.inst);
    chk("m_inst2",   ibf.dec_inst_2, e1.inst);
    chk("m_br1",     32'(ibf.dec_is_branch_1), 32'(e0.br));
    chk("m_br2",     32'(ibf.dec_is_branch_2), 32'(e1.br));
    if (rst) begin
      if (flush) begin
        mq.delete();
      end else begin
        a   = (ibf.dec_accept == 2'd3) ? 2 : int'(ibf.dec_accept);
        eff = (a < sz) ? a : sz;
        if (rdy && ibf.fetch_inst_1_en)
          mq.push_back('{pc: ibf.pc_1_i, inst: ibf.inst_1_i, br: ibf.is_branch_1_i});
        if (rdy && ibf.fetch_inst_2_en)
          mq.push_back('{pc: ibf.pc_2_i, inst: ibf.inst_2_i, br: ibf.is_branch_2_i});
        repeat (eff) void'(mq.pop_front());
      end
    end
  end

  task automatic set_idle();
    ibf.fetch_inst_1_en = 1'b0;
    ibf.fetch_inst_2_en = 1'b0;
    ibf.pc_1_i = '0;  ibf.pc_2_i = '0;
    ibf.inst_1_i = '0; ibf.inst_2_i = '0;
    ibf.is_branch_1_i = 1'b0; ibf.is_branch_2_i = 1'b0;
    ibf.dec_accept = 2'd0;
    flush = 1'b0;
  endtask

  // Apply one cycle of stimulus; returns 1 time unit after the capturing edge.
  task automatic drive(input logic e1, input logic e2, input logic [31:0] p1, input logic [31:0] p2,
                       input logic [31:0] i1, input logic [31:0] i2, input logic b1, input logic b2,
                       input logic [1:0] acc, input logic fl);
    ibf.fetch_inst_1_en = e1;  ibf.fetch_inst_2_en = e2;
    ibf.pc_1_i = p1;           ibf.pc_2_i = p2;
    ibf.inst_1_i = i1;         ibf.inst_2_i = i2;
    ibf.is_branch_1_i = b1;    ibf.is_branch_2_i = b2;
    ibf.dec_accept = acc;      flush = fl;
    @(posedge clk);
    #1;
    set_idle();
  endtask

  task automatic pair(input logic [31:0] p, input logic [1:0] acc);
    drive(1'b1, 1'b1, p, p + 32'd4, ~p, p ^ 32'h00ff00ff, p[3], ~p[3], acc, 1'b0);
  endtask

  task automatic consume(input logic [1:0] acc);
    drive(1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, acc, 1'b0);
  endtask

  initial begin
    set_idle();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_ready", 32'(ibf.fetch_ready), 32'd0);
    chk("rst_valid1", 32'(ibf.dec_valid_1), 32'd0);
    chk("rst_pc1", ibf.dec_pc_1, 32'h0);
    rst = 1'b1;
    #1;
    chk("idle_ready", 32'(ibf.fetch_ready), 32'd1);
    chk("idle_count", 32'(count), 32'd0);

    // Single pair write
    drive(1'b1, 1'b1, 32'h1c000000, 32'h1c000004, 32'h02800421, 32'h02800842, 1'b0, 1'b1, 2'd0, 1'b0);
    chk("pair_count", 32'(count), 32'd2);
    chk("pair_valid2", 32'(ibf.dec_valid_2), 32'd1);
    chk("pair_pc1", ibf.dec_pc_1, 32'h1c000000);
    chk("pair_pc2", ibf.dec_pc_2, 32'h1c000004);
    chk("pair_inst1", ibf.dec_inst_1, 32'h02800421);
    chk("pair_inst2", ibf.dec_inst_2, 32'h02800842);
    chk("pair_br2", 32'(ibf.dec_is_branch_2), 32'd1);
    consume(2'd2);
    chk("drain_count", 32'(count), 32'd0);

    // Slot-2-only write lands at head
    drive(1'b0, 1'b1, 32'h0, 32'h1c000104, 32'h0, 32'h00000013, 1'b0, 1'b1, 2'd0, 1'b0);
    chk("s2_count", 32'(count), 32'd1);
    chk("s2_pc1", ibf.dec_pc_1, 32'h1c000104);
    chk("s2_valid2", 32'(ibf.dec_valid_2), 32'd0);
    chk("s2_pc2_forced", ibf.dec_pc_2, 32'h0);
    consume(2'd1);

    // Fill to full, then back-pressure
    for (int k = 0; k < 8; k++) pair(32'h1c001000 + 32'(8 * k), 2'd0);
    chk("full_count", 32'(count), 32'd16);
    chk("full_ready", 32'(ibf.fetch_ready), 32'd0);
    pair(32'hdead0000, 2'd0);
    chk("drop_count", 32'(count), 32'd16);
    chk("drop_pc1", ibf.dec_pc_1, 32'h1c001000);
    consume(2'd1);
    chk("c15_count", 32'(count), 32'd15);
    chk("c15_ready", 32'(ibf.fetch_ready), 32'd0);
    chk("c15_pc1", ibf.dec_pc_1, 32'h1c001004);
    consume(2'd1);
    chk("c14_count", 32'(count), 32'd14);
    chk("c14_ready", 32'(ibf.fetch_ready), 32'd1);
    repeat (7) consume(2'd2);
    chk("empty_count", 32'(count), 32'd0);

    // Steady stream across the pointer wrap
    for (int k = 0; k < 20; k++) begin
      pair(32'h1c002000 + 32'(8 * k), 2'd2);
      chk("stream_count", 32'(count), 32'd2);
    end
    chk("stream_pc1", ibf.dec_pc_1, 32'h1c002098);
    chk("stream_pc2", ibf.dec_pc_2, 32'h1c00209c);
    consume(2'd1);
    chk("one_count", 32'(count), 32'd1);
    consume(2'd2);
    chk("under_count", 32'(count), 32'd0);
    chk("under_valid1", 32'(ibf.dec_valid_1), 32'd0);
    consume(2'd2);
    chk("under2_count", 32'(count), 32'd0);
    pair(32'h1c002800, 2'd0);
    consume(2'd3);
    chk("acc3_count", 32'(count), 32'd0);

    // Flush beats same-cycle write and consume
    for (int k = 0; k < 3; k++) pair(32'h1c004000 + 32'(8 * k), 2'd0);
    chk("pre_flush_count", 32'(count), 32'd6);
    drive(1'b1, 1'b1, 32'h1c005000, 32'h1c005004, 32'h1, 32'h2, 1'b1, 1'b1, 2'd2, 1'b1);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_valid1", 32'(ibf.dec_valid_1), 32'd0);
    drive(1'b1, 1'b0, 32'h1c003000, 32'h0, 32'h02800c63, 32'h0, 1'b1, 1'b0, 2'd0, 1'b0);
    chk("post_flush_count", 32'(count), 32'd1);
    chk("post_flush_pc1", ibf.dec_pc_1, 32'h1c003000);
    chk("post_flush_br1", 32'(ibf.dec_is_branch_1), 32'd1);

    // Asynchronous reset mid-cycle
    pair(32'h1c006000, 2'd0);
    pair(32'h1c006008, 2'd0);
    chk("pre_rst_count", 32'(count), 32'd5);
    #1;
    rst = 1'b0;
    #1;
    chk("async_rst_count", 32'(count), 32'd0);
    chk("async_rst_valid1", 32'(ibf.dec_valid_1), 32'd0);
    chk("async_rst_ready", 32'(ibf.fetch_ready), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    pair(32'h1c007000, 2'd0);
    chk("after_rst_count", 32'(count), 32'd2);
    chk("after_rst_pc1", ibf.dec_pc_1, 32'h1c007000);
    consume(2'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
